sysctrl_gen: RTL and testbench
==============================

// Module: sysctrl_gen
// PURPOSE
// Generic MCU-facing system control block for all cores; parametrised successor of the fixed per-core control unit.
// Decodes framed SPI byte commands: status/ID, LEDs, RGB colour, buttons, indexed config register file (burst write+readback),
// maskable edge-latched interrupts. Core-specific OSD meanings live outside, as slices of cfg_values.
// PARAMETERS
// CORE_ID      8'h03            core id returned in status byte 3
// NUM_CFG      32               config registers, 8 bit each, index 0..NUM_CFG-1 (1..255)
// CFG_DEFAULT  {NUM_CFG*8{1'b0}}  reset values; register i = CFG_DEFAULT[8*i+7:8*i]
// NUM_INT      8                interrupt sources (1..8); bit 0 reserved for coldboot
// PORTS
// clk             in   1          system clock
// reset           in   1          synchronous, active-high; power-on reset
// data_in_strobe  in   1          one-cycle pulse: data_in valid
// data_in_start   in   1          qualifies strobe: byte is a command opcode
// data_in         in   8          byte from MCU
// data_out        out  8          reply byte, registered; valid from cycle after strobe until next strobe
// int_out_n       out  1          active-low interrupt to MCU
// int_in          in   NUM_INT    interrupt request levels from core; bit 0 ignored
// buttons         in   2          board buttons
// leds            out  2          MCU-driven LEDs
// color           out  24         GRB-ordered colour for ws2812
// cfg_values      out  NUM_CFG*8  flattened config register file
// cfg_strobe      out  NUM_CFG    one-cycle pulse per register written (even if value unchanged)
// BEHAVIOUR
// Reset: leds=0, color=0, data_out=0, cfg=CFG_DEFAULT, cfg_strobe=0, pending=0, mask=all 1, coldboot=1, state=IDLE, cnt=0.
// Framing: start strobe -> opcode latched, cnt=1; each non-start strobe uses cnt then cnt<=cnt+1, saturating 255.
//  Non-start strobe in IDLE ignored. New start mid-command aborts old one; no partial side effects beyond bytes taken.
// Opcodes (cnt = byte index after opcode):
//  0 STATUS: data_out <= 5C,42,CORE_ID,NUM_CFG for cnt 1..4; 00 beyond.
//  1 LEDS: cnt1 leds<=data_in[1:0].
//  2 COLOR: bit-reversed data_in; cnt1->[15:8], cnt2->[7:0], cnt3->[23:16].
//  3 BUTTONS: every byte data_out <= {6'b0,buttons}.
//  4 CFG_WR: cnt1 idx<=data_in; cnt>=2 reg[idx]<=data_in, cfg_strobe[idx] pulses next cycle, idx<=idx+1.
//    idx>=NUM_CFG: write dropped, no strobe; idx wraps 255->0 (8-bit).
//  5 IRQ: every byte data_out <= {pending[7:1],coldboot} (unused bits 0); cnt1 ack: pending<=pending&~data_in,
//    data_in[0] clears coldboot.
//  6 IRQ_MASK: cnt1 mask<=data_in[NUM_INT-1:0]; mask[0] forced 1.
//  7 CFG_RD: cnt1 idx<=data_in; every byte cnt>=1 data_out <= reg[idx] (idx>=NUM_CFG -> 00), idx<=idx+1 after read at cnt>=2.
//  other: bytes consumed, no effect, data_out <= FF.
// Interrupts: pending[i] set on rising edge of int_in[i] (registered prev sample); set beats ack in same cycle.
//  int_out_n = ~(coldboot | |(pending & mask)), combinational from registers.
// Latency: config/LED/colour writes visible 1 cycle after the strobe; readback byte for strobe n visible before strobe n+1.
// STRUCTURE
// sysctrl_defs.vh: opcode localparams, status magic 5C/42, cnt width.
// Sub-module sysctrl_irq: edge detect, pending, mask, coldboot, int_out_n. Cfg register file and decoder stay top-level.
// TESTING
// Reset -> cfg_values==CFG_DEFAULT, int_out_n=0 (coldboot), leds=0; STATUS 00,xx×4 -> 5C,42,03,20.
// CFG_WR 04,05,AA,BB,CC -> reg5=AA,reg6=BB,reg7=CC, cfg_strobe bits 5,6,7 pulse once each; CFG_RD 07,05 + 3 bytes -> AA,BB,CC.
// CFG_WR to idx 31 then 32: reg31 updated, idx32 dropped, no strobe, no other register changed.
// int_in[3] 0->1: pending[3]=1; IRQ 05,01 clears coldboot; IRQ 05,08 with int_in[3] new edge same cycle -> stays pending.
// IRQ_MASK 06,F7 with pending[3]=1, coldboot=0 -> int_out_n=1; mask FF -> int_out_n=0.
// Start byte mid CFG_WR burst, and reset mid-command -> state IDLE, no further writes, registers per reset table.

Source files
------------

// File: rtl/sysctrl_gen_pkg.sv
// Shared opcodes, status magic bytes, frame-counter width and state encoding for the system control block.
package sysctrl_gen_pkg;

  localparam int CNT_W = 8;

  typedef logic [7:0]       byte_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam byte_t OP_STATUS   = 8'h00;
  localparam byte_t OP_LEDS     = 8'h01;
  localparam byte_t OP_COLOR    = 8'h02;
  localparam byte_t OP_BUTTONS  = 8'h03;
  localparam byte_t OP_CFG_WR   = 8'h04;
  localparam byte_t OP_IRQ      = 8'h05;
  localparam byte_t OP_IRQ_MASK = 8'h06;
  localparam byte_t OP_CFG_RD   = 8'h07;

  localparam byte_t STATUS_MAGIC0 = 8'h5C;
  localparam byte_t STATUS_MAGIC1 = 8'h42;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CMD  = 1'b1;

  function automatic byte_t bit_rev8(input byte_t b);
    byte_t r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/sysctrl_gen_if.sv
// Byte-framed MCU link: strobe/start qualified command bytes in, registered reply byte and interrupt line out.
interface sysctrl_gen_if;
  import sysctrl_gen_pkg::*;

  logic  data_in_strobe;
  logic  data_in_start;
  byte_t data_in;
  byte_t data_out;
  logic  int_out_n;

  modport master (
    output data_in_strobe,
    output data_in_start,
    output data_in,
    input  data_out,
    input  int_out_n
  );

  modport slave (
    input  data_in_strobe,
    input  data_in_start,
    input  data_in,
    output data_out,
    output int_out_n
  );

endinterface

// File: rtl/sysctrl_gen_irq.sv
// Interrupt controller: rising-edge latching of core requests, MCU ack and mask, coldboot flag, active-low line.
module sysctrl_gen_irq
  import sysctrl_gen_pkg::*;
#(
  parameter int NUM_INT = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_INT-1:0] int_in,
  input  logic               ack_en,
  input  byte_t              ack_data,
  input  logic               mask_wr,
  input  byte_t              mask_data,
  output byte_t              irq_status,
  output logic               int_out_n
);

  // Source 0 is the coldboot slot; it never latches from int_in and is never masked.
  localparam logic [NUM_INT-1:0] SRC0 = NUM_INT'(1);

  logic [NUM_INT-1:0] int_prev_r;
  logic [NUM_INT-1:0] pending_r;
  logic [NUM_INT-1:0] mask_r;
  logic               coldboot_r;
  logic [NUM_INT-1:0] rise_s;
  logic [NUM_INT-1:0] ack_clr_s;

  assign rise_s    = int_in & ~int_prev_r;
  assign ack_clr_s = ack_en ? ack_data[NUM_INT-1:0] : {NUM_INT{1'b0}};

  // Edge capture, pending/mask/coldboot state; a new edge wins over a same-cycle ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      int_prev_r <= {NUM_INT{1'b0}};
      pending_r  <= {NUM_INT{1'b0}};
      mask_r     <= {NUM_INT{1'b1}};
      coldboot_r <= 1'b1;
    end else begin
      int_prev_r <= int_in;
      pending_r  <= ((pending_r & ~ack_clr_s) | rise_s) & ~SRC0;
      if (mask_wr) begin
        mask_r <= mask_data[NUM_INT-1:0] | SRC0;
      end
      if (ack_en && ack_data[0]) begin
        coldboot_r <= 1'b0;
      end
    end
  end

  // Status byte seen by the MCU: pending sources with coldboot in bit 0.
  always_comb begin
    irq_status    = 8'(pending_r);
    irq_status[0] = coldboot_r;
  end

  assign int_out_n = ~(coldboot_r | (|(pending_r & mask_r)));

endmodule

// File: rtl/sysctrl_gen.sv
// MCU-facing system control block: command framing/decoding, LEDs, colour, config register file, interrupts.
module sysctrl_gen
  import sysctrl_gen_pkg::*;
#(
  parameter byte_t                CORE_ID     = 8'h03,
  parameter int                   NUM_CFG     = 32,
  parameter logic [NUM_CFG*8-1:0] CFG_DEFAULT = {NUM_CFG*8{1'b0}},
  parameter int                   NUM_INT     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  sysctrl_gen_if.slave         bus,
  input  logic [NUM_INT-1:0]   int_in,
  input  logic [1:0]           buttons,
  output logic [1:0]           leds,
  output logic [23:0]          color,
  output logic [NUM_CFG*8-1:0] cfg_values,
  output logic [NUM_CFG-1:0]   cfg_strobe
);

  localparam logic [8:0] NUM_CFG_W = 9'(NUM_CFG);

  logic [0:0]         state_r;
  byte_t              opcode_r;
  cnt_t               cnt_r;
  byte_t              idx_r;
  byte_t              data_out_r;
  logic [1:0]         leds_r;
  logic [23:0]        color_r;
  byte_t              cfg_mem_r [NUM_CFG];
  logic [NUM_CFG-1:0] cfg_strobe_r;

  logic  start_s;
  logic  cmd_byte_s;
  logic  wr_hit_s;
  logic  ack_s;
  logic  mask_wr_s;
  logic  int_out_n_s;
  byte_t rd_idx_s;
  byte_t rd_data_s;
  byte_t status_s;
  byte_t irq_status_s;
  byte_t reply_s;

  assign start_s    = bus.data_in_strobe & bus.data_in_start;
  assign cmd_byte_s = bus.data_in_strobe & ~bus.data_in_start & (state_r == ST_CMD);
  assign wr_hit_s   = cmd_byte_s & (opcode_r == OP_CFG_WR) & (cnt_r >= 8'd2)
                    & ({1'b0, idx_r} < NUM_CFG_W);
  assign ack_s      = cmd_byte_s & (opcode_r == OP_IRQ) & (cnt_r == 8'd1);
  assign mask_wr_s  = cmd_byte_s & (opcode_r == OP_IRQ_MASK) & (cnt_r == 8'd1);
  // The index byte itself already returns the register it names.
  assign rd_idx_s   = (cnt_r == 8'd1) ? bus.data_in : idx_r;

  // Readback mux; indices past the register file read as zero.
  always_comb begin
    rd_data_s = 8'h00;
    for (int i = 0; i < NUM_CFG; i++) begin
      rd_data_s = (rd_idx_s == 8'(i)) ? cfg_mem_r[i] : rd_data_s;
    end
  end

  // Status sequence by byte position.
  always_comb begin
    case (cnt_r)
      8'd1:    status_s = STATUS_MAGIC0;
      8'd2:    status_s = STATUS_MAGIC1;
      8'd3:    status_s = CORE_ID;
      8'd4:    status_s = 8'(NUM_CFG);
      default: status_s = 8'h00;
    endcase
  end

  // Reply byte selection per opcode; write-only commands keep the previous reply.
  always_comb begin
    case (opcode_r)
      OP_STATUS:   reply_s = status_s;
      OP_BUTTONS:  reply_s = {6'b000000, buttons};
      OP_IRQ:      reply_s = irq_status_s;
      OP_CFG_RD:   reply_s = rd_data_s;
      OP_LEDS,
      OP_COLOR,
      OP_CFG_WR,
      OP_IRQ_MASK: reply_s = data_out_r;
      default:     reply_s = 8'hFF;
    endcase
  end

  // Command framing, reply register, LED/colour writes and the shared register index.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      opcode_r   <= 8'h00;
      cnt_r      <= 8'd0;
      idx_r      <= 8'h00;
      data_out_r <= 8'h00;
      leds_r     <= 2'b00;
      color_r    <= 24'h000000;
    end else if (start_s) begin
      state_r  <= ST_CMD;
      opcode_r <= bus.data_in;
      cnt_r    <= 8'd1;
    end else if (cmd_byte_s) begin
      cnt_r      <= (cnt_r == 8'hFF) ? 8'hFF : cnt_r + 8'd1;
      data_out_r <= reply_s;
      case (opcode_r)
        OP_LEDS: begin
          if (cnt_r == 8'd1) leds_r <= bus.data_in[1:0];
        end
        OP_COLOR: begin
          case (cnt_r)
            8'd1:    color_r[15:8]  <= bit_rev8(bus.data_in);
            8'd2:    color_r[7:0]   <= bit_rev8(bus.data_in);
            8'd3:    color_r[23:16] <= bit_rev8(bus.data_in);
            default: ;
          endcase
        end
        OP_CFG_WR,
        OP_CFG_RD: begin
          idx_r <= (cnt_r == 8'd1) ? bus.data_in : idx_r + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Config register file with one-cycle write strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CFG; i++) begin
        cfg_mem_r[i] <= CFG_DEFAULT[8*i +: 8];
      end
      cfg_strobe_r <= {NUM_CFG{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CFG; i++) begin
        if (wr_hit_s && (idx_r == 8'(i))) begin
          cfg_mem_r[i]    <= bus.data_in;
          cfg_strobe_r[i] <= 1'b1;
        end else begin
          cfg_strobe_r[i] <= 1'b0;
        end
      end
    end
  end

  sysctrl_gen_irq #(
    .NUM_INT (NUM_INT)
  ) u_irq (
    .clk        (clk),
    .reset      (reset),
    .int_in     (int_in),
    .ack_en     (ack_s),
    .ack_data   (bus.data_in),
    .mask_wr    (mask_wr_s),
    .mask_data  (bus.data_in),
    .irq_status (irq_status_s),
    .int_out_n  (int_out_n_s)
  );

  for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg_out
    assign cfg_values[8*g +: 8] = cfg_mem_r[g];
  end

  assign bus.data_out  = data_out_r;
  assign bus.int_out_n = int_out_n_s;
  assign leds          = leds_r;
  assign color         = color_r;
  assign cfg_strobe    = cfg_strobe_r;

endmodule

// File: tb/tb_sysctrl_gen.sv
// Directed self-checking bench for sysctrl_gen with hand-computed expected reply bytes and register contents.
module tb_sysctrl_gen;
  import sysctrl_gen_pkg::*;

  function automatic logic [255:0] mk_def();
    logic [255:0] r;
    for (int i = 0; i < 32; i++) begin
      r[8*i +: 8] = 8'(8'hA0 + i);
    end
    return r;
  endfunction

  localparam logic [255:0] TB_DEF = mk_def();

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   int_in = 8'h00;
  logic [1:0]   buttons = 2'b00;
  logic [1:0]   leds;
  logic [23:0]  color;
  logic [255:0] cfg_values;
  logic [31:0]  cfg_strobe;

  int    checks = 0;
  int    errors = 0;
  byte_t exp_cfg [32];

  sysctrl_gen_if bus ();

  sysctrl_gen #(
    .CORE_ID     (8'h03),
    .NUM_CFG     (32),
    .CFG_DEFAULT (TB_DEF),
    .NUM_INT     (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .int_in     (int_in),
    .buttons    (buttons),
    .leds       (leds),
    .color      (color),
    .cfg_values (cfg_values),
    .cfg_strobe (cfg_strobe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic st, input byte_t b);
    @(negedge clk);
    bus.data_in_strobe = 1'b1;
    bus.data_in_start  = st;
    bus.data_in        = b;
    @(negedge clk);
    bus.data_in_strobe = 1'b0;
    bus.data_in_start  = 1'b0;
  endtask

  function automatic logic [255:0] exp_flat();
    logic [255:0] r;
    for (int i = 0; i < 32; i++) begin
      r[8*i +: 8] = exp_cfg[i];
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      exp_cfg[i] = TB_DEF[8*i +: 8];
    end
  endtask

  initial begin
    bus.data_in_strobe = 1'b0;
    bus.data_in_start  = 1'b0;
    bus.data_in        = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_cfg", cfg_values, TB_DEF);
    check("rst_int_n", bus.int_out_n, 1'b0);
    check("rst_leds", leds, 2'b00);
    check("rst_color", color, 24'h000000);
    check("rst_dout", bus.data_out, 8'h00);
    check("rst_strobe", cfg_strobe, 32'h0);

    // Status sequence then zero beyond the fourth byte
    send(1'b1, OP_STATUS);
    send(1'b0, 8'h11); check("st1", bus.data_out, 8'h5C);
    send(1'b0, 8'h22); check("st2", bus.data_out, 8'h42);
    send(1'b0, 8'h33); check("st3", bus.data_out, 8'h03);
    send(1'b0, 8'h44); check("st4", bus.data_out, 8'h20);
    send(1'b0, 8'h55); check("st5", bus.data_out, 8'h00);

    send(1'b1, OP_LEDS);
    send(1'b0, 8'hFE); check("leds", leds, 2'b10);

    send(1'b1, OP_COLOR);
    send(1'b0, 8'h01);
    send(1'b0, 8'h80);
    send(1'b0, 8'h0F); check("color", color, 24'hF08001);

    buttons = 2'b10;
    send(1'b1, OP_BUTTONS);
    send(1'b0, 8'h00); check("btn_a", bus.data_out, 8'h02);
    buttons = 2'b01;
    send(1'b0, 8'h00); check("btn_b", bus.data_out, 8'h01);

    // Burst write starting at register 5
    send(1'b1, OP_CFG_WR);
    send(1'b0, 8'h05); check("wr_idx_nostb", cfg_strobe, 32'h0);
    send(1'b0, 8'hAA); exp_cfg[5] = 8'hAA; check("stb5", cfg_strobe, 32'h0000_0020);
    send(1'b0, 8'hBB); exp_cfg[6] = 8'hBB; check("stb6", cfg_strobe, 32'h0000_0040);
    send(1'b0, 8'hCC); exp_cfg[7] = 8'hCC; check("stb7", cfg_strobe, 32'h0000_0080);
    check("wr_cfg", cfg_values, exp_flat());
    @(negedge clk); check("stb_once", cfg_strobe, 32'h0);

    send(1'b1, OP_CFG_RD);
    send(1'b0, 8'h05);
    send(1'b0, 8'h00); check("rd5", bus.data_out, 8'hAA);
    send(1'b0, 8'h00); check("rd6", bus.data_out, 8'hBB);
    send(1'b0, 8'h00); check("rd7", bus.data_out, 8'hCC);

    // Last register then past the end
    send(1'b1, OP_CFG_WR);
    send(1'b0, 8'h1F);
    send(1'b0, 8'h5E); exp_cfg[31] = 8'h5E; check("stb31", cfg_strobe, 32'h8000_0000);
    send(1'b0, 8'h77); check("stb32", cfg_strobe, 32'h0);
    check("wr_edge_cfg", cfg_values, exp_flat());
    send(1'b1, OP_CFG_RD);
    send(1'b0, 8'h1F);
    send(1'b0, 8'h00); check("rd31", bus.data_out, 8'h5E);
    send(1'b0, 8'h00); check("rd32", bus.data_out, 8'h00);

    // Interrupt edge, coldboot ack, pending readback
    int_in = 8'h08;
    repeat (2) @(negedge clk);
    send(1'b1, OP_IRQ);
    send(1'b0, 8'h01); check("irq_pre", bus.data_out, 8'h09);
    check("irq_line", bus.int_out_n, 1'b0);
    send(1'b1, OP_IRQ);
    send(1'b0, 8'h00); check("irq_cb_clr", bus.data_out, 8'h08);

    // Ack of bit 3 in the same cycle as a fresh edge on bit 3
    int_in = 8'h00;
    repeat (2) @(negedge clk);
    send(1'b1, OP_IRQ);
    @(negedge clk);
    bus.data_in_strobe = 1'b1;
    bus.data_in        = 8'h08;
    int_in             = 8'h08;
    @(negedge clk);
    bus.data_in_strobe = 1'b0;
    check("ack_edge_rd", bus.data_out, 8'h08);
    send(1'b1, OP_IRQ);
    send(1'b0, 8'h00); check("set_beats_ack", bus.data_out, 8'h08);

    send(1'b1, OP_IRQ_MASK);
    send(1'b0, 8'hF7); check("masked", bus.int_out_n, 1'b1);
    send(1'b1, OP_IRQ_MASK);
    send(1'b0, 8'hFF); check("unmasked", bus.int_out_n, 1'b0);

    send(1'b1, OP_IRQ);
    send(1'b0, 8'h08); check("ack_rd", bus.data_out, 8'h08);
    send(1'b0, 8'h00); check("ack_done", bus.data_out, 8'h00);
    check("ack_line", bus.int_out_n, 1'b1);

    int_in = 8'h09;
    repeat (2) @(negedge clk);
    send(1'b1, OP_IRQ);
    send(1'b0, 8'h00); check("bit0_ign", bus.data_out, 8'h00);
    check("bit0_line", bus.int_out_n, 1'b1);

    // New start aborts a write burst
    buttons = 2'b11;
    send(1'b1, OP_CFG_WR);
    send(1'b0, 8'h02);
    send(1'b0, 8'h11); exp_cfg[2] = 8'h11;
    send(1'b1, OP_BUTTONS);
    send(1'b0, 8'h22); check("abort_dout", bus.data_out, 8'h03);
    check("abort_stb", cfg_strobe, 32'h0);
    check("abort_cfg", cfg_values, exp_flat());

    send(1'b1, 8'h09);
    send(1'b0, 8'h12); check("bad_op", bus.data_out, 8'hFF);

    // Reset in the middle of a write burst; the trailing byte must be ignored
    send(1'b1, OP_CFG_WR);
    send(1'b0, 8'h08);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    send(1'b0, 8'h33);
    check("mid_rst_cfg", cfg_values, exp_flat());
    check("mid_rst_stb", cfg_strobe, 32'h0);
    check("mid_rst_leds", leds, 2'b00);
    check("mid_rst_color", color, 24'h000000);
    check("mid_rst_dout", bus.data_out, 8'h00);
    check("mid_rst_int_n", bus.int_out_n, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
